// File: rtl/bcd_time_counter.sv
// hh:mm:ss time-of-day counter in packed 2-digit BCD with tick advance,
// parallel load, per-field adjust and registered carry/error pulses.
module bcd_time_counter #(
  parameter logic [7:0] SEC_MAX  = 8'h59,
  parameter logic [7:0] MIN_MAX  = 8'h59,
  parameter logic [7:0] HOUR_MAX = 8'h23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       run_en,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       adj_inc,
  input  logic [1:0] adj_sel,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       min_carry,
  output logic       hour_carry,
  output logic       day_carry,
  output logic       load_err
);

  localparam logic [1:0] SEL_SS = 2'b00;
  localparam logic [1:0] SEL_MM = 2'b01;
  localparam logic [1:0] SEL_HH = 2'b10;

  // BCD +1 with wrap to 00 once the field sits at its maximum
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max)            r = 8'h00;
    else if (v[3:0] == 4'd9) r = {4'(v[7:4] + 4'd1), 4'h0};
    else                     r = {v[7:4], 4'(v[3:0] + 4'd1)};
    return r;
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  logic [7:0] hh_n, mm_n, ss_n;
  logic       min_n, hour_n, day_n, err_n;
  logic       load_valid, ss_wrap, mm_wrap, hh_wrap;

  assign load_valid = bcd_ok(load_hh, HOUR_MAX) && bcd_ok(load_mm, MIN_MAX)
                      && bcd_ok(load_ss, SEC_MAX);
  assign ss_wrap = (ss == SEC_MAX);
  assign mm_wrap = ss_wrap && (mm == MIN_MAX);
  assign hh_wrap = mm_wrap && (hh == HOUR_MAX);

  // Next-state: load beats adjust beats tick; lower-priority events are dropped
  always_comb begin
    hh_n   = hh;
    mm_n   = mm;
    ss_n   = ss;
    min_n  = 1'b0;
    hour_n = 1'b0;
    day_n  = 1'b0;
    err_n  = 1'b0;
    if (load) begin
      if (load_valid) begin
        hh_n = load_hh;
        mm_n = load_mm;
        ss_n = load_ss;
      end else begin
        err_n = 1'b1;
      end
    end else if (adj_inc) begin
      case (adj_sel)
        SEL_SS:  ss_n = bcd_inc(ss, SEC_MAX);
        SEL_MM:  mm_n = bcd_inc(mm, MIN_MAX);
        SEL_HH:  hh_n = bcd_inc(hh, HOUR_MAX);
        default: ;
      endcase
    end else if (tick_1hz && run_en) begin
      ss_n  = bcd_inc(ss, SEC_MAX);
      min_n = ss_wrap;
      if (ss_wrap) mm_n = bcd_inc(mm, MIN_MAX);
      hour_n = mm_wrap;
      if (mm_wrap) hh_n = bcd_inc(hh, HOUR_MAX);
      day_n = hh_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hh         <= 8'h00;
      mm         <= 8'h00;
      ss         <= 8'h00;
      min_carry  <= 1'b0;
      hour_carry <= 1'b0;
      day_carry  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      hh         <= hh_n;
      mm         <= mm_n;
      ss         <= ss_n;
      min_carry  <= min_n;
      hour_carry <= hour_n;
      day_carry  <= day_n;
      load_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed self-checking bench for bcd_time_counter.
module tb_bcd_time_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz, run_en, load, adj_inc;
  logic [7:0] load_hh, load_mm, load_ss;
  logic [1:0] adj_sel;
  logic [7:0] hh, mm, ss;
  logic       min_carry, hour_carry, day_carry, load_err;

  int total = 0;
  int bad   = 0;

  bcd_time_counter dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .run_en(run_en),
    .load(load), .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .adj_inc(adj_inc), .adj_sel(adj_sel),
    .hh(hh), .mm(mm), .ss(ss),
    .min_carry(min_carry), .hour_carry(hour_carry), .day_carry(day_carry),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  // One clock edge, sample 1 time unit later, then drop the one-shot inputs
  task automatic cyc();
    @(posedge clk);
    #1;
    load     = 1'b0;
    adj_inc  = 1'b0;
    tick_1hz = 1'b0;
  endtask

  task automatic chk_t(input string tag, input logic [23:0] exp);
    total++;
    assert ({hh, mm, ss} === exp) else begin
      bad++;
      $error("FAIL %s: time got %h:%h:%h want %h", tag, hh, mm, ss, exp);
    end
  endtask

  // Pulses packed as {min_carry, hour_carry, day_carry, load_err}
  task automatic chk_p(input string tag, input logic [3:0] exp);
    total++;
    assert ({min_carry, hour_carry, day_carry, load_err} === exp) else begin
      bad++;
      $error("FAIL %s: pulses got %b want %b", tag,
             {min_carry, hour_carry, day_carry, load_err}, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    load = 1'b1; load_hh = h; load_mm = m; load_ss = s;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; run_en = 1'b0; tick_1hz = 1'b0; load = 1'b0; adj_inc = 1'b0;
    adj_sel = 2'b11; load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
    #12;
    chk_t("reset_time", 24'h000000);
    chk_p("reset_pulses", 4'b0000);
    rst_n = 1'b1;
    cyc();
    chk_t("post_reset_idle", 24'h000000);

    // Five ticks from zero
    run_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick_1hz = 1'b1;
      cyc();
      chk_p("tick_no_carry", 4'b0000);
      cyc();
    end
    chk_t("five_ticks", 24'h000005);

    // Seconds wrap into minutes
    do_load(8'h12, 8'h34, 8'h59);
    chk_t("load_123459", 24'h123459);
    tick_1hz = 1'b1; cyc();
    chk_t("tick_to_123500", 24'h123500);
    chk_p("min_carry_pulse", 4'b1000);
    cyc();
    chk_p("min_carry_drop", 4'b0000);

    // Full day rollover
    do_load(8'h23, 8'h59, 8'h59);
    tick_1hz = 1'b1; cyc();
    chk_t("day_wrap", 24'h000000);
    chk_p("all_carries", 4'b1110);
    cyc();
    chk_p("all_carries_drop", 4'b0000);

    // Low-nibble carry into the high nibble
    do_load(8'h00, 8'h00, 8'h09);
    tick_1hz = 1'b1; cyc();
    chk_t("nibble_carry", 24'h000010);

    // Rejected loads leave fields untouched
    do_load(8'h00, 8'h60, 8'h00);
    chk_t("rej_mm60_time", 24'h000010);
    chk_p("rej_mm60_err", 4'b0001);
    cyc();
    chk_p("rej_err_drop", 4'b0000);
    do_load(8'h00, 8'h00, 8'h1A);
    chk_t("rej_ss1a_time", 24'h000010);
    chk_p("rej_ss1a_err", 4'b0001);
    do_load(8'h24, 8'h00, 8'h00);
    chk_t("rej_hh24_time", 24'h000010);
    chk_p("rej_hh24_err", 4'b0001);
    do_load(8'h23, 8'h59, 8'h59);
    chk_p("max_load_ok", 4'b0000);
    chk_t("max_load_time", 24'h235959);

    // Adjust wraps a single field without carrying
    do_load(8'h10, 8'h59, 8'h30);
    adj_inc = 1'b1; adj_sel = 2'b01; cyc();
    chk_t("adj_mm_wrap", 24'h100030);
    chk_p("adj_mm_no_carry", 4'b0000);
    do_load(8'h23, 8'h00, 8'h30);
    adj_inc = 1'b1; adj_sel = 2'b10; cyc();
    chk_t("adj_hh_wrap", 24'h000030);
    chk_p("adj_hh_no_carry", 4'b0000);
    adj_inc = 1'b1; adj_sel = 2'b00; cyc();
    chk_t("adj_ss", 24'h000031);
    adj_inc = 1'b1; adj_sel = 2'b11; cyc();
    chk_t("adj_none", 24'h000031);

    // Priority: load over tick, adjust over tick
    load = 1'b1; tick_1hz = 1'b1; load_hh = 8'h08; load_mm = 8'h00; load_ss = 8'h00;
    cyc();
    chk_t("load_beats_tick", 24'h080000);
    adj_inc = 1'b1; adj_sel = 2'b01; tick_1hz = 1'b1; cyc();
    chk_t("adj_beats_tick", 24'h080100);
    load = 1'b1; adj_inc = 1'b1; adj_sel = 2'b00;
    load_hh = 8'h01; load_mm = 8'h02; load_ss = 8'h03;
    cyc();
    chk_t("load_beats_adj", 24'h010203);

    // Frozen while run_en is low
    run_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_1hz = 1'b1; cyc();
      chk_p("frozen_pulses", 4'b0000);
    end
    chk_t("frozen_time", 24'h010203);

    // Async reset mid-count with a carry pulse in flight
    run_en = 1'b1;
    do_load(8'h00, 8'h00, 8'h59);
    tick_1hz = 1'b1; cyc();
    chk_p("inflight_carry", 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_t("async_reset_time", 24'h000000);
    chk_p("async_reset_pulses", 4'b0000);
    tick_1hz = 1'b1; cyc();
    chk_t("held_in_reset", 24'h000000);
    #2;
    rst_n = 1'b1;
    tick_1hz = 1'b1; cyc();
    chk_t("first_tick_after_reset", 24'h000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
